// File: rtl/stream_fifo_pkg.sv
// stream_fifo_pkg: shared sample type and default sizing for the stream FIFO.
//   SAMPLE_W       - width of one sample from the sample pipeline
//   sample_t       - one sample
//   FIFO_DEPTH_DEF - default number of FIFO entries
package stream_fifo_pkg;

    localparam int SAMPLE_W       = 15;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/stream_fifo_mem.sv
// stream_fifo_mem: DEPTH x WIDTH register array backing the stream FIFO.
// One synchronous write port, one asynchronous (combinational) read port.
// All entries reset to zero.
// Ports:
//   clk   - clock, writes on rising edge
//   rst   - asynchronous active-low reset, clears every entry
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data, mem[raddr]
module stream_fifo_mem
    import stream_fifo_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: elastic first-word-fall-through FIFO between the always-streaming
// sample pipeline and a consumer that may stall.
// Optional feature macro: STREAM_FIFO_WATERMARK_EN enables registered
// almost_full / almost_empty watermark flags; without it both are tied to 0.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   clr               - synchronous flush (pointers, count, overflow to 0)
//   in_data/in_valid/in_ready    - write side handshake
//   out_data/out_valid/out_ready - read side handshake, head shown combinationally
//   count             - occupancy 0..DEPTH
//   overflow          - sticky: a sample was offered while full
//   almost_full/almost_empty     - watermark flags
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int WIDTH    = SAMPLE_W,
    parameter int DEPTH    = FIFO_DEPTH_DEF,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     almost_full,
    output logic                     almost_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (AF_LEVEL > DEPTH) || (AE_LEVEL > DEPTH)) begin : g_bad_params
        $error("stream_fifo: DEPTH must be a power of two >= 2 and levels <= DEPTH");
    end

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Storage: a flush cycle never writes, even if a push is offered.
    stream_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push & ~clr),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

    // Pointer / occupancy / overflow state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef STREAM_FIFO_WATERMARK_EN
    localparam logic [CW-1:0] AF_CNT = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT = CW'(AE_LEVEL);

    // Watermarks follow count one cycle later; an empty FIFO is almost empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count >= AF_CNT);
            almost_empty <= (count <= AE_CNT);
        end
    end
`else
    assign almost_full  = 1'b0;
    assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
module tb_stream_fifo;
    import stream_fifo_pkg::*;

    localparam int DEPTH = 4;
`ifdef STREAM_FIFO_WATERMARK_EN
    localparam bit WM = 1'b1;
`else
    localparam bit WM = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        clr;
    sample_t     in_data;
    logic        in_valid;
    logic        in_ready;
    sample_t     out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;
    logic        overflow;
    logic        almost_full;
    logic        almost_empty;

    stream_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .overflow     (overflow),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // reference model
    sample_t sb[$];
    sample_t mmem [DEPTH];
    int      mwp, mrp, mcount;
    bit      mov, maf, mae;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        mwp = 0; mrp = 0; mcount = 0;
        mov = 1'b0; maf = 1'b0; mae = WM;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_count"},     32'(count),     32'(mcount));
        chk({tag, "_in_ready"},  32'(in_ready),  32'(mcount != DEPTH));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(mcount != 0));
        chk({tag, "_overflow"},  32'(overflow),  32'(mov));
        chk({tag, "_out_data"},  32'(out_data),  32'(mmem[mrp]));
        chk({tag, "_af"},        32'(almost_full),  32'(maf));
        chk({tag, "_ae"},        32'(almost_empty), 32'(mae));
    endtask

    // One clock: check popped head against the scoreboard, advance the model, check state.
    task automatic tick(input string tag);
        bit mpush, mpop, naf, nae;
        mpush = in_valid && (mcount != DEPTH) && !clr;
        mpop  = out_ready && (mcount != 0) && !clr;
        naf   = WM && (mcount >= DEPTH - 1);
        nae   = WM && (mcount <= 1);
        if (mpop) begin
            chk({tag, "_pop_data"}, 32'(out_data), 32'(sb[0]));
            void'(sb.pop_front());
        end
        @(posedge clk);
        #1;
        if (clr) begin
            sb.delete();
            mwp = 0; mrp = 0; mcount = 0; mov = 1'b0;
        end else begin
            if (in_valid && mcount == DEPTH) mov = 1'b1;
            if (mpush) begin
                mmem[mwp] = in_data;
                sb.push_back(in_data);
                mwp = (mwp + 1) % DEPTH;
            end
            if (mpop) mrp = (mrp + 1) % DEPTH;
            mcount = mcount + int'(mpush) - int'(mpop);
        end
        maf = naf;
        mae = nae;
        chk_state(tag);
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        model_reset();
        #22;
        chk_state("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // fill with out_ready low
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = sample_t'(i);
            tick("fill");
        end
        in_valid = 1'b0;
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head", 32'(out_data), 32'h0001);
        chk("full_overflow", 32'(overflow), 32'd0);

        // offer while full
        in_valid = 1'b1; in_data = 15'h7FFF;
        tick("ovf");
        in_valid = 1'b0;
        tick("ovf_hold");
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // drain
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick("drain");
        out_ready = 1'b0;
        chk("drain_count", 32'(count), 32'd0);

        // streaming at full rate
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = sample_t'(16'h0100 + i);
            tick("stream");
            chk("stream_cnt_le1", 32'(count <= 3'd1), 32'd1);
        end
        in_valid = 1'b0;
        tick("stream_tail");
        out_ready = 1'b0;

        // simultaneous push/pop at count=2
        in_valid = 1'b1;
        in_data = 15'h0A0A; tick("two");
        in_data = 15'h0B0B; tick("two");
        in_data = 15'h0C0C; out_ready = 1'b1; tick("pushpop");
        chk("pushpop_count", 32'(count), 32'd2);
        in_valid = 1'b0;
        tick("pp_drain");
        tick("pp_drain");
        out_ready = 1'b0;

        // fill to 3 then flush with push and pop offered; write slot 0 is next
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = sample_t'(16'h0200 + i);
            tick("prefill");
        end
        clr = 1'b1; in_data = 15'h5555; out_ready = 1'b1;
        tick("clr");
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_overflow", 32'(overflow), 32'd0);
        tick("clr_after");

        // watermark fill 0 -> 4
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = sample_t'(16'h0300 + i);
            tick("wm_fill");
        end
        in_valid = 1'b0;
        tick("wm_full");
        chk("wm_af_full", 32'(almost_full), 32'(WM));

        // asynchronous reset in the middle of a fill
        out_ready = 1'b1;
        tick("wm_pop");
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 15'h0444;
        tick("refill");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk_state("mid_rst");
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        tick("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
